// File: rtl/iir_out_capture.sv
// -----------------------------------------------------------------------------
// iir_out_capture
//
// Capture stage for the IIR filter output stream. After a start pulse it waits
// for the filter to report a stable output, discards SKIP_N settled samples,
// then stores one frame of DEPTH samples in an on-chip buffer while tracking
// the peak magnitude. The buffer is readable at any time through a registered
// read port.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, abort     single-cycle arm / abort pulses (abort has priority)
//   s_data/s_valid   filter output sample and qualifier (no backpressure)
//   s_stable         filter stable indication
//   rd_en/rd_addr    read request; rd_data/rd_valid one cycle later
//   busy             high while waiting, skipping or capturing
//   done             frame complete (level, until start or abort)
//   wr_addr          next buffer write address
//   peak_abs         max |sample| written in the current frame (saturating)
//   unstable_seen    sticky: a sample was written while s_stable was low
// -----------------------------------------------------------------------------
module iir_out_capture #(
  parameter int DW     = 24,
  parameter int AW     = 11,
  parameter int DEPTH  = 2048,
  parameter int SKIP_N = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_stable,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] peak_abs,
  output logic          unstable_seen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STABLE,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Skip counter holds 1..SKIP_N-1; the SKIP_N-th sample exits SKIP directly.
  localparam int SCW = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
  localparam logic [SCW-1:0] SKIP_LAST = SCW'(SKIP_N - 1);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [DW-1:0]  S_MIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]  S_MAX     = {1'b0, {(DW-1){1'b1}}};

  state_t          state;
  logic [SCW-1:0]  skip_cnt;
  logic [DW-1:0]   samp_abs;
  logic            wr_en;

  logic [DW-1:0]   mem [DEPTH];

  // Magnitude with saturation: the most negative value has no positive twin.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    samp_abs = s_data;
    if (s_data[DW-1]) begin
      samp_abs = (s_data == S_MIN) ? S_MAX : -s_data;
    end
  end

  // A sample is stored in CAPTURE, or straight from WAIT_STABLE when there is
  // nothing to skip. An abort in the same cycle suppresses the write.
  always_comb begin
    wr_en = 1'b0;
    case (state)
      S_CAPTURE:     wr_en = s_valid && !abort;
      S_WAIT_STABLE: wr_en = s_valid && s_stable && !abort && (SKIP_N == 0);
      default:       wr_en = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_addr       <= '0;
      skip_cnt      <= '0;
      peak_abs      <= '0;
      unstable_seen <= 1'b0;
    end else if (abort) begin
      // Buffer, peak and sticky flag are deliberately kept for inspection.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (wr_en && (samp_abs > peak_abs)) begin
        peak_abs <= samp_abs;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_WAIT_STABLE;
            busy          <= 1'b1;
            done          <= 1'b0;
            wr_addr       <= '0;
            skip_cnt      <= '0;
            peak_abs      <= '0;
            unstable_seen <= 1'b0;
          end
        end
        S_WAIT_STABLE: begin
          if (s_valid && s_stable) begin
            if (SKIP_N == 0) begin
              state   <= S_CAPTURE;
              wr_addr <= AW'(1);
            end else if (SKIP_N == 1) begin
              state <= S_CAPTURE;
            end else begin
              state    <= S_SKIP;
              skip_cnt <= SCW'(1);
            end
          end
        end
        S_SKIP: begin
          if (s_valid) begin
            if (skip_cnt == SKIP_LAST) begin
              state <= S_CAPTURE;
            end else begin
              skip_cnt <= skip_cnt + SCW'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (s_valid) begin
            wr_addr <= wr_addr + AW'(1);   // wraps to 0 after the last word
            if (!s_stable) begin
              unstable_seen <= 1'b1;
            end
            if (wr_addr == ADDR_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the sample buffer has no reset so it maps onto block RAM; its
  // contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= s_data;
    end
  end

  // Registered read; a same-address write in the same cycle returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_iir_out_capture.sv
// -----------------------------------------------------------------------------
// tb_iir_out_capture
//
// Directed bench for iir_out_capture. Two instances share all inputs: u_dut
// with SKIP_N=16 and u_dut0 with SKIP_N=0. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_iir_out_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [23:0] s_data;
  logic        s_valid, s_stable;
  logic        rd_en;
  logic [10:0] rd_addr;

  logic [23:0] rd_data, peak_abs, rd_data0, peak_abs0;
  logic        rd_valid, busy, done, unstable_seen;
  logic        rd_valid0, busy0, done0, unstable_seen0;
  logic [10:0] wr_addr, wr_addr0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iir_out_capture #(.DW(24), .AW(11), .DEPTH(2048), .SKIP_N(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_stable(s_stable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .wr_addr(wr_addr), .peak_abs(peak_abs),
    .unstable_seen(unstable_seen)
  );

  iir_out_capture #(.DW(24), .AW(11), .DEPTH(2048), .SKIP_N(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_stable(s_stable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .busy(busy0), .done(done0), .wr_addr(wr_addr0), .peak_abs(peak_abs0),
    .unstable_seen(unstable_seen0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] d, input logic v, input logic s);
    s_data = d; s_valid = v; s_stable = s;
    tick();
  endtask

  task automatic pulse_start();
    s_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic read_both(input logic [10:0] a);
    s_valid = 1'b0; rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (rd_data !== 24'd0 || rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        wr_addr !== 11'd0 || peak_abs !== 24'd0 || unstable_seen !== 1'b0) begin
      bad++;
      $display("FAIL %s: got rd_data=%h rd_valid=%b busy=%b done=%b wr_addr=%0d peak=%h unst=%b, want all zero",
               tag, rd_data, rd_valid, busy, done, wr_addr, peak_abs, unstable_seen);
    end
    total++;
    if (rd_data0 !== 24'd0 || rd_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        wr_addr0 !== 11'd0 || peak_abs0 !== 24'd0 || unstable_seen0 !== 1'b0) begin
      bad++;
      $display("FAIL %s_skip0: got rd_data=%h rd_valid=%b busy=%b done=%b wr_addr=%0d peak=%h unst=%b, want all zero",
               tag, rd_data0, rd_valid0, busy0, done0, wr_addr0, peak_abs0, unstable_seen0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_reset_values("reset_asserted");
    rst_n = 1'b1;
    tick(); tick();
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    int n_done = 0, n_done0 = 0, errs = 0, errs0 = 0;
    pulse_start();
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL basic_busy_rise: got busy=%b done=%b want 1 0", busy, done);
    end
    for (int n = 1; n <= 2200; n++) begin
      drive(24'(n - 1), 1'b1, 1'b1);
      if (done0 && n_done0 == 0) n_done0 = n;
      if (done) begin n_done = n; break; end
    end
    s_valid = 1'b0;
    total++;
    if (n_done != 2064) begin bad++; $display("FAIL basic_done_time: got %0d want 2064", n_done); end
    total++;
    if (n_done0 != 2048) begin bad++; $display("FAIL skip0_done_time: got %0d want 2048", n_done0); end
    total++;
    if (busy !== 1'b0 || wr_addr !== 11'd0) begin
      bad++; $display("FAIL basic_busy_fall: got busy=%b wr_addr=%0d want 0 0", busy, wr_addr);
    end
    total++;
    if (peak_abs !== 24'd2063 || unstable_seen !== 1'b0) begin
      bad++; $display("FAIL basic_peak: got peak=%0d unst=%b want 2063 0", peak_abs, unstable_seen);
    end
    drive(24'h123, 1'b1, 1'b1); drive(24'h456, 1'b1, 1'b1); s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || wr_addr !== 11'd0) begin
      bad++; $display("FAIL basic_done_hold: got done=%b wr_addr=%0d want 1 0", done, wr_addr);
    end
    for (int k = 0; k < 2048; k++) begin
      read_both(11'(k));
      if (rd_data !== 24'(k + 16)) errs++;
      if (rd_data0 !== 24'(k)) errs0++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL basic_frame: got %0d bad words want 0", errs); end
    total++;
    if (errs0 != 0) begin bad++; $display("FAIL skip0_frame: got %0d bad words want 0", errs0); end
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_high: got %b want 1", rd_valid); end
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 24'd2063) begin
      bad++; $display("FAIL rd_hold: got rd_valid=%b rd_data=%0d want 0 2063", rd_valid, rd_data);
    end
  endtask

  task automatic test_late_stable();
    int n_done = 0;
    pulse_start();
    for (int n = 0; n < 2400; n++) begin
      drive(24'(n), 1'b1, n >= 100);
      if (done) begin n_done = n + 1; break; end
    end
    s_valid = 1'b0;
    total++;
    if (n_done != 2164) begin bad++; $display("FAIL late_done_time: got %0d want 2164", n_done); end
    read_both(11'd0);
    total++;
    if (rd_data !== 24'd116) begin bad++; $display("FAIL late_mem0: got %0d want 116", rd_data); end
    total++;
    if (rd_data0 !== 24'd100) begin bad++; $display("FAIL late_skip0_mem0: got %0d want 100", rd_data0); end
    read_both(11'd2047);
    total++;
    if (rd_data !== 24'd2163) begin bad++; $display("FAIL late_mem2047: got %0d want 2163", rd_data); end
    total++;
    if (peak_abs !== 24'd2163) begin bad++; $display("FAIL late_peak: got %0d want 2163", peak_abs); end
  endtask

  // Runs over the late-stable frame, so mem[k] starts as k+116.
  task automatic test_gapped();
    int coll_err = 0, new_err = 0;
    logic [23:0] dk;
    pulse_start();
    for (int i = 0; i < 16; i++) drive(24'h0, 1'b1, 1'b1);
    for (int k = 0; k < 2048; k++) begin
      dk = 24'h100000 + 24'(k);
      if (k == 30) begin
        pulse_start();
        total++;
        if (wr_addr !== 11'd30 || busy !== 1'b1) begin
          bad++; $display("FAIL start_ignored: got wr_addr=%0d busy=%b want 30 1", wr_addr, busy);
        end
      end
      if (k < 40) begin
        rd_en = 1'b1; rd_addr = 11'(k);
        drive(dk, 1'b1, k != 20);
        if (rd_data !== 24'(k + 116)) coll_err++;
        drive(dk, 1'b0, 1'b1);
        if (rd_data !== dk) new_err++;
        rd_en = 1'b0;
        if (k == 19) begin
          total++;
          if (unstable_seen !== 1'b0) begin bad++; $display("FAIL unstable_early: got %b want 0", unstable_seen); end
        end
      end else begin
        drive(dk, 1'b1, 1'b1);
      end
    end
    s_valid = 1'b0;
    total++;
    if (coll_err != 0) begin bad++; $display("FAIL read_first: got %0d bad reads want 0", coll_err); end
    total++;
    if (new_err != 0) begin bad++; $display("FAIL read_after_write: got %0d bad reads want 0", new_err); end
    total++;
    if (done !== 1'b1 || unstable_seen !== 1'b1) begin
      bad++; $display("FAIL gapped_done_unst: got done=%b unst=%b want 1 1", done, unstable_seen);
    end
    total++;
    if (peak_abs !== 24'h1007FF) begin bad++; $display("FAIL gapped_peak: got %h want 1007ff", peak_abs); end
    read_both(11'd20);
    total++;
    if (rd_data !== 24'h100014) begin bad++; $display("FAIL unstable_stored: got %h want 100014", rd_data); end
  endtask

  task automatic test_abort();
    int n_done = 0;
    pulse_start();
    for (int n = 0; n <= 515; n++) drive(24'h200000 + 24'(n), 1'b1, 1'b1);
    s_valid = 1'b0;
    total++;
    if (wr_addr !== 11'd500 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre: got wr_addr=%0d busy=%b want 500 1", wr_addr, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (peak_abs !== 24'h200203 || unstable_seen !== 1'b0) begin
      bad++; $display("FAIL abort_retain: got peak=%h unst=%b want 200203 0", peak_abs, unstable_seen);
    end
    for (int i = 0; i < 5; i++) drive(24'h7, 1'b1, 1'b1);
    s_valid = 1'b0;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL start_abort_same: got busy=%b done=%b want 0 0", busy, done);
    end
    drive(24'h7, 1'b1, 1'b1); s_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stays_idle: got busy=%b want 0", busy); end
    pulse_start();
    for (int n = 1; n <= 2200; n++) begin
      drive(24'(n - 1), 1'b1, 1'b1);
      if (done) begin n_done = n; break; end
    end
    s_valid = 1'b0;
    total++;
    if (n_done != 2064 || peak_abs !== 24'd2063) begin
      bad++; $display("FAIL rearm_frame: got cycles=%0d peak=%0d want 2064 2063", n_done, peak_abs);
    end
    read_both(11'd0);
    total++;
    if (rd_data !== 24'd16) begin bad++; $display("FAIL rearm_mem0: got %0d want 16", rd_data); end
    read_both(11'd499);
    total++;
    if (rd_data !== 24'd515) begin bad++; $display("FAIL rearm_mem499: got %0d want 515", rd_data); end
  endtask

  task automatic test_saturation();
    logic [23:0] d;
    pulse_start();
    for (int i = 0; i < 16; i++) drive(24'h0, 1'b1, 1'b1);
    for (int k = 0; k < 2100 && !done; k++) begin
      d = (k == 5) ? 24'h800000 : (k == 6) ? 24'h7FFFF0 : 24'h0;
      drive(d, 1'b1, 1'b1);
    end
    s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || peak_abs !== 24'h7FFFFF) begin
      bad++; $display("FAIL peak_saturate: got done=%b peak=%h want 1 7fffff", done, peak_abs);
    end
    pulse_start();
    for (int k = 0; k < 2100 && !done; k++) drive(24'hFFFFFF, 1'b1, 1'b1);
    s_valid = 1'b0;
    total++;
    if (done !== 1'b1 || peak_abs !== 24'd1 || peak_abs0 !== 24'd1) begin
      bad++; $display("FAIL peak_minus_one: got done=%b peak=%h peak0=%h want 1 1 1", done, peak_abs, peak_abs0);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int n = 0; n < 1016; n++) begin
      if (n == 1015) begin rd_en = 1'b1; rd_addr = 11'd0; end
      drive(24'(n), 1'b1, 1'b1);
    end
    rd_en = 1'b0; s_valid = 1'b0;
    total++;
    if (wr_addr !== 11'd1000 || busy !== 1'b1 || rd_data !== 24'd16) begin
      bad++; $display("FAIL reset_mid_pre: got wr_addr=%0d busy=%b rd_data=%0d want 1000 1 16", wr_addr, busy, rd_data);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_mid");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) drive(24'h111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(24'h55 + 24'(i), 1'b1, 1'b1);
    s_valid = 1'b0;
    total++;
    if (wr_addr0 !== 11'd4 || wr_addr !== 11'd0 || busy0 !== 1'b1) begin
      bad++; $display("FAIL skip0_addr: got wr_addr0=%0d wr_addr=%0d busy0=%b want 4 0 1", wr_addr0, wr_addr, busy0);
    end
    read_both(11'd0);
    total++;
    if (rd_data0 !== 24'h55) begin bad++; $display("FAIL skip0_first: got %h want 55", rd_data0); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_data = '0; s_valid = 1'b0; s_stable = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    #1;
    test_reset();
    test_basic();
    test_late_stable();
    test_gapped();
    test_abort();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
